// File: rtl/rs232_pkg.sv
// Shared types and helpers for the RS-232 transmit arbiter.
// Other arbiter files pull these in with import rs232_pkg::*.
package rs232_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE,
    OWN
  } state_e;

  // Grants never exceed 8 requesters, so a fixed 8-bit one-hot input covers every N.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs232_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     pick_o,
  output logic             any_req_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   pick_rot;
  logic [2*N-1:0] pick_dbl;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, then rotate back.
  always_comb begin
    req_dbl  = {req_i, req_i} >> ptr_i;
    req_rot  = req_dbl[N-1:0];
    pick_rot = req_rot & (-req_rot);
    pick_dbl = {pick_rot, pick_rot} << ptr_i;
    pick_o   = pick_dbl[2*N-1:N];
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin sharing of one rs232_send transmitter between N byte-stream requesters,
// with atomic packets (capped at MAX_BURST bytes per grant) and a one-byte holding register.
module rs232_tx_arbiter
  import rs232_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_valid,
  input  logic [BYTE_W*N-1:0]   req_data,
  input  logic [N-1:0]          req_last,
  output logic [N-1:0]          req_ready,
  output logic [BYTE_W-1:0]     tx_byte,
  output logic                  tx_en,
  input  logic                  tx_data_clk,
  output logic [N-1:0]          grant,
  output logic                  busy
);

  localparam int PTR_W = $clog2(N);

  state_e            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [7:0]        burst_q, burst_d;
  logic [BYTE_W-1:0] hold_byte_q, hold_byte_d;
  logic              hold_valid_q, hold_valid_d;
  logic              release_q, release_d;
  logic              dc_q;

  logic [N-1:0]      pick;
  logic              any_req;
  logic              fall;
  logic              accept;
  logic              sel_last;
  logic [BYTE_W-1:0] sel_data;
  logic [2:0]        grant_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic [7:0]        burst_inc;

  rr_arbiter #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .pick_o    (pick),
    .any_req_o (any_req)
  );

  assign req_ready = (state_q == OWN && !hold_valid_q) ? grant_q : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel_last  = |(req_last & grant_q);
  assign fall      = dc_q & ~tx_data_clk;
  assign burst_inc = burst_q + 8'd1;
  assign grant_idx = onehot_to_idx(8'(grant_q));
  assign next_ptr  = (int'(grant_idx) >= N - 1) ? '0 : PTR_W'(int'(grant_idx) + 1);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) sel_data = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  // Accept and consume are mutually exclusive: one needs the holding register empty, the other full.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    burst_d      = burst_q;
    hold_byte_d  = hold_byte_q;
    hold_valid_d = hold_valid_q;
    release_d    = release_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = OWN;
          grant_d = pick;
          burst_d = '0;
        end
      end
      OWN: begin
        if (accept) begin
          hold_byte_d  = sel_data;
          hold_valid_d = 1'b1;
          burst_d      = burst_inc;
          if (sel_last || burst_inc == 8'(MAX_BURST)) release_d = 1'b1;
        end
        if (fall && hold_valid_q) begin
          hold_valid_d = 1'b0;
          if (release_q) begin
            grant_d   = '0;
            ptr_d     = next_ptr;
            state_d   = IDLE;
            release_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      burst_q      <= '0;
      hold_byte_q  <= '0;
      hold_valid_q <= 1'b0;
      release_q    <= 1'b0;
      dc_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      burst_q      <= burst_d;
      hold_byte_q  <= hold_byte_d;
      hold_valid_q <= hold_valid_d;
      release_q    <= release_d;
      dc_q         <= tx_data_clk;
    end
  end

  assign tx_en   = hold_valid_q;
  assign tx_byte = hold_byte_q;
  assign grant   = grant_q;
  assign busy    = (state_q == OWN) | hold_valid_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Bench for rs232_tx_arbiter: directed steps plus random packet traffic scored against
// a packet-level round-robin model that predicts the transmitted byte stream and its owners.
module tb_rs232_tx_arbiter;

  localparam int N         = 4;
  localparam int MAX_BURST = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_byte;
  logic           tx_en;
  logic           tx_data_clk;
  logic [N-1:0]   grant;
  logic           busy;

  int checks;
  int errors;
  int modelPtr;

  // Per-requester pending bytes {last, data}; expected stream entries {release, owner[2:0], data}.
  logic [8:0]  reqQ [N][$];
  logic [11:0] expQ [$];

  rs232_tx_arbiter #(
    .N         (N),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_byte     (tx_byte),
    .tx_en       (tx_en),
    .tx_data_clk (tx_data_clk),
    .grant       (grant),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      if (reqQ[i].size() > 0) begin
        h = reqQ[i][0];
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = h[7:0];
        req_last[i]         = h[8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
    end
  endtask

  task automatic pushPacket(input int r, input int len, input logic [7:0] firstByte, input bit randomData);
    logic [7:0] d;
    for (int b = 0; b < len; b++) begin
      d = randomData ? 8'($urandom) : 8'(int'(firstByte) + b * 8'h11);
      reqQ[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, d});
    end
  endtask

  // Packet-level model: whole grants taken in round-robin order over requesters with pending data.
  task automatic buildExpected();
    logic [8:0] mq [N][$];
    logic [8:0] e;
    int pick;
    int cnt;
    int idx;
    bit rel;
    for (int i = 0; i < N; i++) mq[i] = reqQ[i];
    expQ.delete();
    forever begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        idx = (modelPtr + k) % N;
        if (pick < 0 && mq[idx].size() > 0) pick = idx;
      end
      if (pick < 0) break;
      cnt = 0;
      rel = 1'b0;
      while (!rel && mq[pick].size() > 0) begin
        e = mq[pick].pop_front();
        cnt++;
        rel = e[8] || (cnt == MAX_BURST);
        expQ.push_back({rel, 3'(pick), e[7:0]});
      end
      modelPtr = (pick + 1) % N;
    end
  endtask

  // Plays both the requesters and a transmitter that takes 0-3 extra cycles per byte,
  // with occasional spurious data_clk falls while nothing is held.
  task automatic runTraffic();
    int budget;
    int waitCnt;
    bit haveByte;
    bit dcLow;
    bit consumed;
    logic [7:0]   curByte;
    logic [11:0]  head;
    logic [11:0]  lastCons;
    logic [N-1:0] acc;
    buildExpected();
    budget   = expQ.size() * 12 + 40;
    haveByte = 1'b0;
    dcLow    = 1'b0;
    consumed = 1'b0;
    waitCnt  = 0;
    curByte  = '0;
    lastCons = '0;
    for (int cyc = 0; cyc < budget && (expQ.size() > 0 || dcLow || consumed); cyc++) begin
      checkOutput("ready_while_held", 32'(tx_en && (req_ready != '0)), 32'd0);
      if (consumed) begin
        checkOutput("consume_clears_hold", 32'(tx_en), 32'd0);
        checkOutput("grant_after_consume", 32'(grant),
                    lastCons[11] ? 32'd0 : (32'd1 << lastCons[10:8]));
        consumed = 1'b0;
      end else if (haveByte) begin
        checkOutput("tx_en_held", 32'(tx_en), 32'd1);
        checkOutput("tx_byte_stable", 32'(tx_byte), 32'(curByte));
      end else if (tx_en) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_byte", 32'(tx_en), 32'd0);
        end else begin
          head = expQ[0];
          checkOutput("tx_byte", 32'(tx_byte), 32'(head[7:0]));
          checkOutput("grant_owner", 32'(grant), 32'd1 << head[10:8]);
          haveByte = 1'b1;
          curByte  = tx_byte;
          waitCnt  = $urandom_range(0, 3);
        end
      end

      if (dcLow) begin
        tx_data_clk = 1'b1;
        dcLow       = 1'b0;
      end else if (haveByte && waitCnt == 0) begin
        tx_data_clk = 1'b0;
        dcLow       = 1'b1;
        haveByte    = 1'b0;
        lastCons    = expQ.pop_front();
        consumed    = 1'b1;
      end else if (haveByte) begin
        waitCnt--;
      end else if ($urandom_range(0, 5) == 0) begin
        tx_data_clk = 1'b0;
        dcLow       = 1'b1;
      end

      applyStimulus();
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
      end
    end
    checkOutput("stream_drained", 32'(expQ.size()), 32'd0);
    tx_data_clk = 1'b1;
    req_valid   = '0;
    for (int i = 0; i < N; i++) reqQ[i].delete();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n       = 1'b0;
    req_valid   = '0;
    req_last    = '0;
    tx_data_clk = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    modelPtr = 0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    modelPtr    = 0;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    tx_data_clk = 1'b1;

    #12;
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_tx_en", 32'(tx_en), 32'd0);
    checkOutput("reset_tx_byte", 32'(tx_byte), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-byte packet from requester 2, stepped cycle by cycle.
    req_valid        = 4'b0100;
    req_data[23:16]  = 8'hA5;
    req_last         = 4'b0100;
    @(posedge clk);
    #1;
    checkOutput("a5_grant", 32'(grant), 32'h4);
    checkOutput("a5_ready", 32'(req_ready), 32'h4);
    checkOutput("a5_tx_en_before", 32'(tx_en), 32'd0);
    checkOutput("a5_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    checkOutput("a5_ready_pulse", 32'(req_ready), 32'd0);
    checkOutput("a5_tx_en", 32'(tx_en), 32'd1);
    checkOutput("a5_tx_byte", 32'(tx_byte), 32'hA5);
    @(posedge clk);
    #1;
    checkOutput("a5_tx_byte_hold", 32'(tx_byte), 32'hA5);
    checkOutput("a5_grant_hold", 32'(grant), 32'h4);
    tx_data_clk = 1'b0;
    @(posedge clk);
    #1;
    tx_data_clk = 1'b1;
    checkOutput("a5_grant_released", 32'(grant), 32'd0);
    checkOutput("a5_tx_en_cleared", 32'(tx_en), 32'd0);
    checkOutput("a5_busy_cleared", 32'(busy), 32'd0);
    modelPtr = 3;
    @(posedge clk);
    #1;

    // All four requesters with one byte each: pointer left at 3 by the previous packet.
    for (int r = 0; r < N; r++) pushPacket(r, 1, 8'(8'h30 + r), 1'b0);
    runTraffic();

    // From a fresh pointer, five single-byte packets (requester 0 has two).
    doReset();
    pushPacket(0, 1, 8'h40, 1'b0);
    pushPacket(0, 1, 8'h41, 1'b0);
    for (int r = 1; r < N; r++) pushPacket(r, 1, 8'(8'h50 + r), 1'b0);
    runTraffic();

    // 40-byte packet split by MAX_BURST, interleaved with requester 2.
    pushPacket(1, 40, 8'h00, 1'b1);
    pushPacket(2, 1, 8'hC2, 1'b0);
    pushPacket(2, 1, 8'hC3, 1'b0);
    runTraffic();

    // Requester 0 sends 11, 22, 33 as one packet.
    pushPacket(0, 3, 8'h11, 1'b0);
    runTraffic();

    for (int round = 0; round < 4; round++) begin
      for (int r = 0; r < N; r++) begin
        for (int p = $urandom_range(0, 2); p > 0; p--) begin
          pushPacket(r, ($urandom_range(0, 3) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 6),
                     8'h00, 1'b1);
        end
      end
      runTraffic();
    end

    // Asynchronous reset while requester 1 holds the grant and a byte is held.
    doReset();
    req_valid       = 4'b0010;
    req_data[15:8]  = 8'h5C;
    req_last        = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("areset_grant_before", 32'(grant), 32'h2);
    @(posedge clk);
    #1;
    req_valid = '0;
    checkOutput("areset_tx_en_before", 32'(tx_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_tx_en", 32'(tx_en), 32'd0);
    checkOutput("areset_grant", 32'(grant), 32'd0);
    checkOutput("areset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("areset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    modelPtr = 0;
    @(posedge clk);
    #1;
    pushPacket(3, 1, 8'hE3, 1'b0);
    pushPacket(0, 1, 8'hE0, 1'b0);
    runTraffic();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
